force_overlay_bank: RTL and testbench
=====================================

Name: force_overlay_bank

Overview:
- Parametrised bank of NCH driven registers, each WIDTH bits, with a per-bit force/release overlay. Models the force-enable / force-value / forced-read scheme in synthesizable RTL.
- A command port applies full or bit-range forces and releases, plus a sequenced release-all.
- The read port returns the effective (overlaid) value of any channel.
- Sits beside the simulator force/release regression targets as a multi-channel, partial-range, cycle-accurate reference model.

Parameters:
- WIDTH, 64, bits per channel (1..512).
- NCH, 4, number of channels (1..16). CHW = max(1, $clog2(NCH)) is derived.
- INIT_PAT, {WIDTH/2{2'b10}} padded with 0 at the LSB for odd WIDTH, driver reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  advance all driver registers.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=NOP, 1=FORCE, 2=RELEASE, 3=RELEASE_ALL.
- cmd_ch  in  CHW  target channel.
- cmd_lsb  in  9  range low bit.
- cmd_msb  in  9  range high bit.
- cmd_val  in  WIDTH  force value, right-aligned (bit 0 maps to cmd_lsb).
- rd_ch  in  CHW  read channel select.
- rd_data  out  WIDTH  effective value of rd_ch, registered.
- rd_forced  out  1  any bit of rd_ch forced, registered.
- busy  out  1  release-all sweep in progress.
- err  out  1  sticky illegal-command flag.

Behaviour:
- Per channel state: drv[ch], en[ch] (force enable mask), val[ch] (force value).
- Effective value: eff = (en & val) | (~en & drv).
- Reset: drv = INIT_PAT, en = 0, val = 0, rd_data = INIT_PAT of ch 0 contents, rd_forced = 0, busy = 0, err = 0, cmd_ready = 1, FSM = IDLE.
- tick: every drv[ch] <= drv[ch] + 1, modulo 2^WIDTH, wraps silently. The driver advances regardless of force; forcing never stops the driver.
- FORCE, accepted in cycle N, for bits i in [cmd_lsb, cmd_msb]:
  - en[ch][i] <= 1; val[ch][i] <= cmd_val[i - cmd_lsb].
  - Bits outside the range are untouched.
- RELEASE: en[ch][i] <= 0 for bits in range; val is left stale.
- Range rules:
  - cmd_msb >= WIDTH is clamped to WIDTH-1.
  - cmd_lsb > cmd_msb (after clamp), or cmd_ch >= NCH: command is consumed with no state change and err <= 1.
  - err clears only on rst.
- NOP is consumed with no effect.
- FSM:
  - IDLE: RELEASE_ALL accepted -> SWEEP, idx = 0, busy = 1, cmd_ready = 0.
  - SWEEP: en[idx] <= 0 each cycle; when idx == NCH-1 -> IDLE with busy = 0 and cmd_ready = 1 on the next cycle.
  - Total sweep is NCH cycles after acceptance. tick continues during the sweep.
- Read latency: 1 cycle. rd_data in cycle N+1 reflects rd_ch and all state updated at the cycle-N edge, so a command accepted at edge N is visible at N+1.
- Same-cycle tick and FORCE: both apply. Forced bits show the new val; unforced bits show drv+1.
- rst mid-sweep: aborts to IDLE, all state back to reset values.

Optional Feature:
- Macro: FORCE_RELEASE_HOLD_EN.
- Defined: variable semantics. On RELEASE or sweep clear, drv bits in range are loaded with val bits in the same cycle, so the forced value persists until the next tick. A same-cycle tick applies +1 to the held value.
- Undefined: net semantics. Released bits show drv immediately.

Test Plan (WIDTH=64, NCH=4):
1. Reset -> rd_data = 64'hAAAAAAAAAAAAAAAA for every rd_ch, rd_forced = 0, busy = 0, err = 0. One tick -> 64'hAAAAAAAAAAAAAAAB.
2. FORCE ch1 [63:0] = 64'h5555555555555555; two ticks -> rd_ch = 1 reads 64'h5555555555555555, rd_forced = 1; ch0 reads ...AAAC.
3. Partial force: from reset, FORCE ch2 [31:0] = 32'h55555555 -> 64'hAAAAAAAA55555555. RELEASE [15:0] -> 64'hAAAAAAAA5555AAAA (macro off).
4. Macro on: FORCE ch3 [7:0] = 8'h00, then RELEASE -> reads 64'hAAAAAAAAAAAAAA00; after one tick -> ...AA01.
5. Force all 4 channels, then RELEASE_ALL -> busy high for exactly 4 cycles, cmd_ready low; any cmd_valid during the sweep is not accepted; afterwards rd_forced = 0 on all channels.
6. Illegal commands:
   - FORCE with lsb = 40, msb = 20 -> no change, err = 1.
   - FORCE with msb = 100, lsb = 60 -> clamped to [63:60].
   - rst asserted mid-sweep -> all reset values next cycle.

Source files
------------

// File: rtl/force_overlay_bank.sv
// NCH-channel driver bank with a per-bit force/release overlay and a registered read port.
// Define FORCE_RELEASE_HOLD_EN for hold-on-release (variable) semantics; default is net semantics.
module force_overlay_bank #(
  parameter int WIDTH = 64,
  parameter int NCH = 4,
  parameter logic [WIDTH-1:0] INIT_PAT = WIDTH'({((WIDTH + 1) / 2){2'b10}} << (WIDTH % 2)),
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CHW-1:0]   cmd_ch,
  input  logic [8:0]       cmd_lsb,
  input  logic [8:0]       cmd_msb,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic [CHW-1:0]   rd_ch,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_forced,
  output logic             busy,
  output logic             err
);

  // state   | meaning
  // S_IDLE  | accepting commands
  // S_SWEEP | release-all in progress, clearing en[idx] one channel per cycle
  typedef enum logic {S_IDLE, S_SWEEP} state_e;

  localparam logic [1:0] OP_FORCE   = 2'd1;
  localparam logic [1:0] OP_RELEASE = 2'd2;
  localparam logic [1:0] OP_RELALL  = 2'd3;

  state_e           state_q, state_d;
  logic [CHW-1:0]   idx_q, idx_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] drv_q [NCH];
  logic [WIDTH-1:0] drv_d [NCH];
  logic [WIDTH-1:0] en_q  [NCH];
  logic [WIDTH-1:0] en_d  [NCH];
  logic [WIDTH-1:0] val_q [NCH];
  logic [WIDTH-1:0] val_d [NCH];
  logic [WIDTH-1:0] clr_mask [NCH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_forced_q, rd_forced_d;

  logic             cmd_acc;
  logic             ch_ok;
  logic             range_ok;
  logic             is_ranged_op;
  logic             do_force;
  logic             do_release;
  logic             do_relall;
  logic             sweep_clr;
  logic [8:0]       msb_clamped;
  logic [WIDTH-1:0] range_mask;
  logic [WIDTH-1:0] val_aligned;
  logic [NCH-1:0]   ch_sel;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_SWEEP);
  assign sweep_clr = busy;
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign rd_forced = rd_forced_q;

  // Command decode: msb is clamped to the channel width before the range check.
  always_comb begin
    msb_clamped  = (int'(cmd_msb) >= WIDTH) ? 9'(WIDTH - 1) : cmd_msb;
    range_ok     = (cmd_lsb <= msb_clamped);
    ch_ok        = (int'(cmd_ch) < NCH);
    cmd_acc      = cmd_valid && cmd_ready;
    is_ranged_op = (cmd_op == OP_FORCE) || (cmd_op == OP_RELEASE);
    do_force     = cmd_acc && (cmd_op == OP_FORCE) && range_ok && ch_ok;
    do_release   = cmd_acc && (cmd_op == OP_RELEASE) && range_ok && ch_ok;
    do_relall    = cmd_acc && (cmd_op == OP_RELALL);
    err_d        = err_q | (cmd_acc && is_ranged_op && !(range_ok && ch_ok));
    val_aligned  = cmd_val << cmd_lsb;
    range_mask   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      range_mask[i] = (9'(i) >= cmd_lsb) && (9'(i) <= msb_clamped);
    end
    ch_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_sel[c] = (cmd_ch == CHW'(c));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (do_relall) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == CHW'(NCH - 1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CHW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Per-channel next state; the driver keeps counting whether or not bits are forced.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      clr_mask[c] = '0;
      if (sweep_clr && (idx_q == CHW'(c))) begin
        clr_mask[c] = '1;
      end else if (do_release && ch_sel[c]) begin
        clr_mask[c] = range_mask;
      end

      drv_d[c] = drv_q[c];
`ifdef FORCE_RELEASE_HOLD_EN
      drv_d[c] = (drv_q[c] & ~(clr_mask[c] & en_q[c])) | (val_q[c] & clr_mask[c] & en_q[c]);
`endif
      if (tick) begin
        drv_d[c] = drv_d[c] + WIDTH'(1);
      end

      en_d[c]  = en_q[c] & ~clr_mask[c];
      val_d[c] = val_q[c];
      if (do_force && ch_sel[c]) begin
        en_d[c]  = en_q[c] | range_mask;
        val_d[c] = (val_q[c] & ~range_mask) | (val_aligned & range_mask);
      end
    end
  end

  // Read is taken from next-state values so a command is visible one cycle after acceptance.
  always_comb begin
    rd_data_d   = '0;
    rd_forced_d = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == CHW'(c)) begin
        rd_data_d   = (en_d[c] & val_d[c]) | (~en_d[c] & drv_d[c]);
        rd_forced_d = |en_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= INIT_PAT;
      rd_forced_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        drv_q[c] <= INIT_PAT;
        en_q[c]  <= '0;
        val_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_forced_q <= rd_forced_d;
      for (int c = 0; c < NCH; c++) begin
        drv_q[c] <= drv_d[c];
        en_q[c]  <= en_d[c];
        val_q[c] <= val_d[c];
      end
    end
  end

endmodule

// File: tb/tb_force_overlay_bank.sv
// Self-checking bench for force_overlay_bank (WIDTH=64, NCH=4): directed steps plus random traffic
// checked against a bit-level reference model of the force/release rules.
module tb_force_overlay_bank;
  localparam int W = 64;
  localparam int N = 4;
  localparam logic [63:0] INIT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_ch = 2'd0;
  logic [8:0]  cmd_lsb = 9'd0;
  logic [8:0]  cmd_msb = 9'd0;
  logic [63:0] cmd_val = 64'd0;
  logic [1:0]  rd_ch = 2'd0;
  logic [63:0] rd_data;
  logic        rd_forced;
  logic        busy;
  logic        err;

  force_overlay_bank #(.WIDTH(W), .NCH(N)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_val(cmd_val),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_forced(rd_forced), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [63:0] m_drv [N];
  logic [63:0] m_en  [N];
  logic [63:0] m_val [N];
  logic        m_err;
  int          sweep_q[$];
  logic [63:0] m_rd;
  logic        m_rdf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Released forced bits keep their forced value in the driver when hold semantics are built in.
  task automatic hold_load(input int ch, input int lo, input int hi);
`ifdef FORCE_RELEASE_HOLD_EN
    for (int i = lo; i <= hi; i++) if (m_en[ch][i]) m_drv[ch][i] = m_val[ch][i];
`endif
  endtask

  task automatic model_edge();
    bit acc;
    int lo, hi, ch;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_drv[c] = INIT; m_en[c] = '0; m_val[c] = '0;
      end
      m_err = 1'b0;
      sweep_q.delete();
      m_rd  = INIT;
      m_rdf = 1'b0;
      return;
    end
    acc = cmd_valid && (sweep_q.size() == 0);
    if (sweep_q.size() != 0) begin
      ch = sweep_q.pop_front();
      hold_load(ch, 0, W - 1);
      m_en[ch] = '0;
    end
    if (acc) begin
      lo = int'(cmd_lsb);
      hi = (int'(cmd_msb) > W - 1) ? W - 1 : int'(cmd_msb);
      ch = int'(cmd_ch);
      if (cmd_op == 2'd1 || cmd_op == 2'd2) begin
        if (lo > hi) m_err = 1'b1;
        else if (cmd_op == 2'd1) begin
          for (int i = lo; i <= hi; i++) begin
            m_en[ch][i]  = 1'b1;
            m_val[ch][i] = cmd_val[i - lo];
          end
        end else begin
          hold_load(ch, lo, hi);
          for (int i = lo; i <= hi; i++) m_en[ch][i] = 1'b0;
        end
      end else if (cmd_op == 2'd3) begin
        for (int c = 0; c < N; c++) sweep_q.push_back(c);
      end
    end
    if (tick) for (int c = 0; c < N; c++) m_drv[c] = m_drv[c] + 64'd1;
    m_rd  = (m_en[rd_ch] & m_val[rd_ch]) | (~m_en[rd_ch] & m_drv[rd_ch]);
    m_rdf = |m_en[rd_ch];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_data", rd_data, m_rd);
    chk("rd_forced", 64'(rd_forced), 64'(m_rdf));
    chk("busy", 64'(busy), 64'(sweep_q.size() != 0));
    chk("cmd_ready", 64'(cmd_ready), 64'(sweep_q.size() == 0));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; tick = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] ch, input int lsb, input int msb,
                       input logic [63:0] v);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch;
    cmd_lsb = 9'(lsb); cmd_msb = 9'(msb); cmd_val = v;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // 1: reset values on every channel, then one tick
    do_reset();
    do_reset();
    for (int r = 0; r < N; r++) begin
      rd_ch = 2'(r);
      step();
      chk("tp1_init", rd_data, INIT);
      chk("tp1_forced", 64'(rd_forced), 64'd0);
    end
    rd_ch = 2'd0; tick = 1'b1;
    step();
    tick = 1'b0;
    chk("tp1_tick", rd_data, 64'hAAAA_AAAA_AAAA_AAAB);

    // 2: full force survives ticks, other channels keep counting
    do_reset();
    issue(2'd1, 2'd1, 0, 63, 64'h5555_5555_5555_5555);
    tick = 1'b1; step(); step(); tick = 1'b0;
    rd_ch = 2'd1; step();
    chk("tp2_forced_val", rd_data, 64'h5555_5555_5555_5555);
    chk("tp2_forced_flag", 64'(rd_forced), 64'd1);
    rd_ch = 2'd0; step();
    chk("tp2_ch0", rd_data, 64'hAAAA_AAAA_AAAA_AAAC);

    // 3: partial force and partial release
    do_reset();
    rd_ch = 2'd2;
    issue(2'd1, 2'd2, 0, 31, 64'h0000_0000_5555_5555);
    chk("tp3_force", rd_data, 64'hAAAA_AAAA_5555_5555);
    issue(2'd2, 2'd2, 0, 15, 64'd0);
`ifdef FORCE_RELEASE_HOLD_EN
    chk("tp3_release", rd_data, 64'hAAAA_AAAA_5555_5555);
`else
    chk("tp3_release", rd_data, 64'hAAAA_AAAA_5555_AAAA);
`endif

    // 4: release then tick
    do_reset();
    rd_ch = 2'd3;
    issue(2'd1, 2'd3, 0, 7, 64'h0);
    chk("tp4_force", rd_data, 64'hAAAA_AAAA_AAAA_AA00);
    issue(2'd2, 2'd3, 0, 7, 64'h0);
    tick = 1'b1; step(); tick = 1'b0;
`ifdef FORCE_RELEASE_HOLD_EN
    chk("tp4_tick", rd_data, 64'hAAAA_AAAA_AAAA_AA01);
`else
    chk("tp4_tick", rd_data, 64'hAAAA_AAAA_AAAA_AAAB);
`endif

    // 5: release-all sweep with a command held pending throughout
    do_reset();
    for (int c = 0; c < N; c++) issue(2'd1, 2'(c), 0, 63, {$urandom, $urandom});
    issue(2'd3, 2'd0, 0, 0, 64'd0);
    cnt = busy ? 1 : 0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_ch = 2'd0; cmd_lsb = 9'd0; cmd_msb = 9'd63;
    cmd_val = 64'h1234_5678_9ABC_DEF0;
    for (int k = 0; k < 8; k++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      if (!busy) break;
      cnt++;
    end
    cmd_valid = 1'b0; tick = 1'b0;
    chk("tp5_busy_cycles", 64'(cnt), 64'd4);
    for (int r = 0; r < N; r++) begin
      rd_ch = 2'(r);
      step();
      chk("tp5_released", 64'(rd_forced), 64'd0);
    end

    // 6: illegal range, clamped range, reset mid-sweep
    do_reset();
    rd_ch = 2'd0;
    issue(2'd1, 2'd0, 40, 20, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("tp6_err", 64'(err), 64'd1);
    chk("tp6_nochange", rd_data, INIT);
    issue(2'd1, 2'd0, 60, 100, 64'h0);
    chk("tp6_clamp", rd_data, 64'h0AAA_AAAA_AAAA_AAAA);
    issue(2'd3, 2'd0, 0, 0, 64'd0);
    step();
    chk("tp6_midsweep", 64'(busy), 64'd1);
    do_reset();
    chk("tp6_rst_data", rd_data, INIT);
    chk("tp6_rst_busy", 64'(busy), 64'd0);
    chk("tp6_rst_err", 64'(err), 64'd0);
    chk("tp6_rst_ready", 64'(cmd_ready), 64'd1);
    step();
    chk("tp6_rst_unforced", 64'(rd_forced), 64'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      int lsb;
      rst       = ($urandom_range(0, 99) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cmd_ch    = 2'($urandom_range(0, N - 1));
      lsb       = $urandom_range(0, 70);
      cmd_lsb   = 9'(lsb);
      cmd_msb   = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                               : 9'($urandom_range(lsb, 127));
      cmd_val   = {$urandom, $urandom};
      rd_ch     = 2'($urandom_range(0, N - 1));
      step();
    end
    rst = 1'b0; cmd_valid = 1'b0; tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
